mem_sram_adapter: RTL and testbench

Request/response bus front-end for the simulation SRAM model. Accepts core-side memory transactions on a valid/grant request channel, drives the SRAM's chip-enable, byte-strobe, address and write-data pins, captures the one-cycle-latency read data, and returns every transaction as an in-order response on a valid/ack channel with a two-entry response buffer. It sits directly upstream of the SRAM model, between the instruction/data fetch logic and the memory.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_rsp_fifo.sv | 69 ++++++
 rtl/mem_sram_adapter.sv | 125 ++++++++++++
 tb/tb_mem_sram_adapter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the SRAM adapter slice: default geometry, derived
// widths, the response-entry type and width helper functions.
// Revision: 1.0
// ============================================================================
package mem_pkg;

  localparam int MEM_WIDTH    = 64;
  localparam int MEM_DEPTH    = 1024;
  localparam int MEM_STRB_W   = MEM_WIDTH / 8;
  localparam int MEM_OFF_BITS = $clog2(MEM_STRB_W);
  localparam int MEM_AW       = $clog2(MEM_DEPTH * MEM_STRB_W) + 1;

  // One response-buffer entry at the default geometry.
  typedef struct packed {
    logic [MEM_WIDTH-1:0] rdata;
    logic                 error;
  } mem_rsp_t;

  // Byte-address width: one bit beyond the SRAM byte range so that
  // out-of-range word indices remain visible to the adapter.
  function automatic int mem_aw(input int width, input int depth);
    return $clog2(depth * (width / 8)) + 1;
  endfunction

  // Number of byte-offset bits inside one data word.
  function automatic int mem_off_bits(input int width);
    return $clog2(width / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rsp_fifo.sv
`default_nettype none
// ============================================================================
// mem_rsp_fifo
// ----------------------------------------------------------------------------
// Two-entry synchronous response FIFO. A push and a pop in the same cycle
// are both honoured, including when the FIFO is full (the pop frees the
// slot the push writes into).
// Ports: g_clk, g_rst (async, active-high), push/wdata, pop/rdata,
//        full, empty, count (0..2).
// Revision: 1.0
// ============================================================================
module mem_rsp_fifo #(
  parameter int DW = 65
) (
  input  logic          g_clk,
  input  logic          g_rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [1:0]    cnt_q,  cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign count = cnt_q;
  assign rdata = mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = ~wptr_q;
    end
    if (do_pop) begin
      rptr_d = ~rptr_q;
    end
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_sram_adapter.sv
`default_nettype none
// ============================================================================
// mem_sram_adapter
// ----------------------------------------------------------------------------
// Valid/grant request front-end for a one-cycle-latency SRAM. Drives the
// SRAM pins combinationally from accepted requests, captures read data one
// cycle later and returns in-order responses through a 2-entry buffer.
// Ports: g_clk, g_rst (async, active-high)
//        mem_req/mem_gnt/mem_wen/mem_strb/mem_addr/mem_wdata  request side
//        mem_recv/mem_ack/mem_rdata/mem_error                response side
//        sram_cen/sram_wstrb/sram_addr/sram_wdata/sram_rdata  SRAM pins
// Build option: MEM_SRAM_ADAPTER_CHECK_EN enables out-of-range and
//        write-to-ROM error responses.
// Revision: 1.0
// ============================================================================
module mem_sram_adapter
  import mem_pkg::*;
#(
  parameter  int WIDTH  = MEM_WIDTH,
  parameter  int DEPTH  = MEM_DEPTH,
  parameter  int ROM    = 0,
  localparam int STRB_W = WIDTH / 8,
  localparam int AW     = mem_aw(WIDTH, DEPTH)
) (
  input  logic              g_clk,
  input  logic              g_rst,
  input  logic              mem_req,
  output logic              mem_gnt,
  input  logic              mem_wen,
  input  logic [STRB_W-1:0] mem_strb,
  input  logic [AW-1:0]     mem_addr,
  input  logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_recv,
  input  logic              mem_ack,
  output logic [WIDTH-1:0]  mem_rdata,
  output logic              mem_error,
  output logic              sram_cen,
  output logic [STRB_W-1:0] sram_wstrb,
  output logic [AW-2:0]     sram_addr,
  output logic [WIDTH-1:0]  sram_wdata,
  input  logic [WIDTH-1:0]  sram_rdata
);

  localparam int c_off = mem_off_bits(WIDTH);
  localparam int c_dw  = WIDTH + 1;

  logic             inflight_q,     inflight_d;
  logic             inflight_rd_q,  inflight_rd_d;
  logic             inflight_err_q, inflight_err_d;

  logic             accept;
  logic             req_err;
  logic [1:0]       cnt;
  logic             fifo_push, fifo_pop, fifo_empty, fifo_full_unused;
  logic [1:0]       fifo_cnt;
  logic [c_dw-1:0]  fifo_wdata, fifo_rdata;

`ifdef MEM_SRAM_ADAPTER_CHECK_EN
  localparam logic [AW-c_off-1:0] c_depth = (AW - c_off)'(DEPTH);
  logic [AW-c_off-1:0] word_idx;

  assign word_idx = mem_addr[AW-1:c_off];
  assign req_err  = (word_idx >= c_depth) | ((ROM != 0) & mem_wen);
`else
  logic unused_cfg;

  assign req_err    = 1'b0;
  assign unused_cfg = ^{mem_addr[AW-1], (ROM != 0)};
`endif

  // Occupancy counts the transaction still inside the SRAM so the buffer
  // always has a slot waiting for it.
  assign cnt      = fifo_cnt + 2'(inflight_q);
  assign mem_recv = ~fifo_empty;
  assign fifo_pop = mem_recv & mem_ack;
  assign mem_gnt  = ~g_rst & ((cnt < 2'd2) | fifo_pop);
  assign accept   = mem_req & mem_gnt;

  // Erroneous requests are accepted but never reach the SRAM.
  assign sram_cen   = accept & ~req_err;
  assign sram_wstrb = (sram_cen & mem_wen) ? mem_strb : '0;
  assign sram_addr  = mem_addr[AW-2:0] & ~((AW - 1)'(STRB_W - 1));
  assign sram_wdata = mem_wdata;

  // Only successful reads carry SRAM data; writes and errors return zero.
  assign fifo_push  = inflight_q;
  assign fifo_wdata = {(inflight_rd_q ? sram_rdata : {WIDTH{1'b0}}), inflight_err_q};

  assign mem_rdata  = mem_recv ? fifo_rdata[c_dw-1:1] : '0;
  assign mem_error  = mem_recv & fifo_rdata[0];

  always_comb begin
    inflight_d     = accept;
    inflight_rd_d  = accept & ~mem_wen & ~req_err;
    inflight_err_d = accept & req_err;
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      inflight_q     <= 1'b0;
      inflight_rd_q  <= 1'b0;
      inflight_err_q <= 1'b0;
    end else begin
      inflight_q     <= inflight_d;
      inflight_rd_q  <= inflight_rd_d;
      inflight_err_q <= inflight_err_d;
    end
  end

  mem_rsp_fifo #(
    .DW (c_dw)
  ) u_rsp_fifo (
    .g_clk (g_clk),
    .g_rst (g_rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_sram_adapter.sv
`default_nettype none
// ============================================================================
// tb_mem_sram_adapter
// ----------------------------------------------------------------------------
// Directed bench for mem_sram_adapter with a behavioural SRAM and a
// scoreboard of expected responses. Expected read data comes from a
// reference memory image kept by the bench, independent of the SRAM model.
// Revision: 1.0
// ============================================================================
module tb_mem_sram_adapter;

  localparam int WIDTH  = 64;
  localparam int DEPTH  = 1024;
  localparam int STRB_W = 8;
  localparam int AW     = 14;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic              g_clk = 1'b0;
  logic              g_rst;
  logic              mem_req, mem_gnt, mem_wen;
  logic [STRB_W-1:0] mem_strb;
  logic [AW-1:0]     mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_recv, mem_ack, mem_error;
  logic [WIDTH-1:0]  mem_rdata;
  logic              sram_cen;
  logic [STRB_W-1:0] sram_wstrb;
  logic [AW-2:0]     sram_addr;
  logic [WIDTH-1:0]  sram_wdata;
  logic [WIDTH-1:0]  sram_rdata = '0;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbq [$];
  int   pop_cyc [$];
  exp_t mon_e;

  logic [63:0] sram_mem [DEPTH];
  logic [63:0] ref_mem  [DEPTH];

  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc <= cyc + 1;

  mem_sram_adapter #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ROM   (0)
  ) dut (
    .g_clk      (g_clk),
    .g_rst      (g_rst),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_wen    (mem_wen),
    .mem_strb   (mem_strb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_recv   (mem_recv),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_error  (mem_error),
    .sram_cen   (sram_cen),
    .sram_wstrb (sram_wstrb),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Behavioural SRAM: byte-strobed write, registered read data.
  always @(posedge g_clk) begin
    if (sram_cen) begin
      for (int b = 0; b < STRB_W; b++)
        if (sram_wstrb[b]) sram_mem[sram_addr[12:3]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      sram_rdata <= sram_mem[sram_addr[12:3]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: compares every handshaken response with the scoreboard
  // and checks that a stalled response holds its payload.
  always @(negedge g_clk) begin
    if (!g_rst && mem_recv && mem_ack) begin
      if (sbq.size() == 0) begin
        chk("rsp_without_request", 64'(sbq.size()), 64'd1);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_rdata", mem_rdata, mon_e.rdata);
        chk("rsp_error", 64'(mem_error), 64'(mon_e.err));
        pop_cyc.push_back(cyc);
      end
    end else if (!g_rst && mem_recv && !mem_ack && sbq.size() != 0) begin
      chk("hold_rdata", mem_rdata, sbq[0].rdata);
    end
  end

  // Present one request for one cycle; record the expected response if granted.
  task automatic issue(input logic wen, input logic [AW-1:0] addr, input logic [7:0] strb,
                       input logic [63:0] wdata, output logic acc);
    exp_t e;
    logic err;
    int   widx;
    mem_req   = 1'b1;
    mem_wen   = wen;
    mem_addr  = addr;
    mem_strb  = strb;
    mem_wdata = wdata;
    @(negedge g_clk);
    acc  = mem_gnt;
    err  = 1'b0;
`ifdef MEM_SRAM_ADAPTER_CHECK_EN
    err  = (addr[AW-1:3] >= 11'd1024);
`endif
    widx = int'(addr[12:3]);
    chk("sram_cen", 64'(sram_cen), 64'(acc & !err));
    chk("sram_wstrb", 64'(sram_wstrb), 64'((acc && !err && wen) ? strb : 8'h00));
    if (acc) begin
      if (wen && !err)
        for (int b = 0; b < 8; b++)
          if (strb[b]) ref_mem[widx][b*8 +: 8] = wdata[b*8 +: 8];
      e.rdata = (wen || err) ? 64'h0 : ref_mem[widx];
      e.err   = err;
      sbq.push_back(e);
    end
    @(posedge g_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    mem_req = 1'b0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge g_clk);
      n++;
    end
    chk("drain_timeout", 64'(sbq.size()), 64'd0);
    @(posedge g_clk);
    #1;
  endtask

  // Single read on an idle adapter: response must appear exactly two cycles
  // after acceptance with the given payload.
  task automatic read_lat(input string tag, input logic [AW-1:0] addr,
                          input logic [63:0] exp_data, input logic exp_err);
    logic acc;
    issue(1'b0, addr, 8'h00, 64'h0, acc);
    mem_req = 1'b0;
    chk({tag, "_gnt"}, 64'(acc), 64'd1);
    @(negedge g_clk);
    chk({tag, "_recv_n1"}, 64'(mem_recv), 64'd0);
    @(negedge g_clk);
    chk({tag, "_recv_n2"}, 64'(mem_recv), 64'd1);
    chk({tag, "_rdata"}, mem_rdata, exp_data);
    chk({tag, "_error"}, 64'(mem_error), 64'(exp_err));
    drain();
  endtask

  initial begin
    logic acc;
    int   n_acc;
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = {32'(i), 32'hC0DE0000 ^ 32'(i)};
      ref_mem[i]  = {32'(i), 32'hC0DE0000 ^ 32'(i)};
    end
    g_rst = 1'b1; mem_req = 1'b1; mem_wen = 1'b0; mem_ack = 1'b0;
    mem_strb = '0; mem_addr = '0; mem_wdata = '0;

    // Reset state, with a request pending to prove the grant is held off.
    repeat (2) @(negedge g_clk);
    chk("rst_gnt",   64'(mem_gnt),   64'd0);
    chk("rst_recv",  64'(mem_recv),  64'd0);
    chk("rst_rdata", mem_rdata,      64'd0);
    chk("rst_error", 64'(mem_error), 64'd0);
    chk("rst_cen",   64'(sram_cen),  64'd0);
    @(posedge g_clk); #1;
    g_rst = 1'b0; mem_req = 1'b0; mem_ack = 1'b1;
    @(negedge g_clk);
    chk("idle_gnt", 64'(mem_gnt), 64'd1);
    @(posedge g_clk); #1;

    // Full-word write then read back.
    issue(1'b1, 14'h10, 8'hFF, 64'h1122334455667788, acc);
    drain();
    read_lat("rd_full", 14'h10, 64'h1122334455667788, 1'b0);

    // Partial write on the low four byte lanes, unaligned address bits ignored.
    issue(1'b1, 14'h13, 8'h0F, 64'hAAAAAAAABBBBBBBB, acc);
    drain();
    read_lat("rd_part", 14'h10, 64'h11223344BBBBBBBB, 1'b0);

    // Eight back-to-back reads with acknowledge held high.
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 14'((int'($urandom_range(0, DEPTH-1)) * 8) + int'($urandom_range(0, 7))),
            8'h00, 64'h0, acc);
      chk("b2b_gnt", 64'(acc), 64'd1);
    end
    drain();
    chk("b2b_count", 64'(pop_cyc.size()), 64'd8);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("b2b_consecutive", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

    // Backpressure: only two transactions fit while responses are not taken.
    mem_ack = 1'b0;
    n_acc   = 0;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 14'(8 * (i + 40)), 8'h00, 64'h0, acc);
      if (acc) n_acc++;
    end
    chk("bp_accepted", 64'(n_acc), 64'd2);
    chk("bp_gnt_low", 64'(acc), 64'd0);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 14'(8 * (i + 60)), 8'h00, 64'h0, acc);
      chk("bp_release_gnt", 64'(acc), 64'd1);
    end
    drain();

    // Reset with two responses pending: nothing stale may come out afterwards.
    mem_ack = 1'b0;
    issue(1'b0, 14'h100, 8'h00, 64'h0, acc);
    issue(1'b0, 14'h108, 8'h00, 64'h0, acc);
    mem_req = 1'b0;
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("pre_rst_recv", 64'(mem_recv), 64'd1);
    #2;
    g_rst = 1'b1;
    #1;
    chk("mid_rst_recv", 64'(mem_recv), 64'd0);
    chk("mid_rst_gnt",  64'(mem_gnt),  64'd0);
    sbq.delete();
    @(posedge g_clk); #1;
    g_rst   = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge g_clk);
      chk("post_rst_no_recv", 64'(mem_recv), 64'd0);
    end
    @(posedge g_clk); #1;
    read_lat("rd_after_rst", 14'h10, 64'h11223344BBBBBBBB, 1'b0);

`ifdef MEM_SRAM_ADAPTER_CHECK_EN
    // Word index 1024 is one past the end of the SRAM.
    read_lat("rd_oor", 14'h2000, 64'h0, 1'b1);
    read_lat("rd_ok_after_oor", 14'h10, 64'h11223344BBBBBBBB, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
